// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC capture path: widths, FSM states and
// the offset-binary to two's-complement conversion.
package adc_pkg;

  localparam int ADC_W    = 14;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } adc_state_e;

  // Inverting the MSB recentres the code on zero; the inverted MSB is then the sign.
  function automatic logic [SAMPLE_W-1:0] offset_to_signed(input logic [ADC_W-1:0] code);
    return {{(SAMPLE_W-ADC_W){~code[ADC_W-1]}}, ~code[ADC_W-1], code[ADC_W-2:0]};
  endfunction

endpackage

// File: rtl/adc_frame_counter.sv
// Sample index within a signal cycle; flags the first and last sample of each
// frame of ppc_i samples and wraps back to zero after the last one.
module adc_frame_counter
  import adc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] ppc_i,
  input  logic             advance_i,
  input  logic             clear_i,
  output logic             sop_o,
  output logic             eop_o
);

  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;
  logic [CNT_W-1:0] ppcLast;

  assign ppcLast = ppc_i - CNT_W'(1);
  assign sop_o   = (idx_q == '0);
  assign eop_o   = (idx_q == ppcLast);

  // The >= guard keeps the index in range even if ppc_i were ever below idx_q.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (advance_i) begin
      idx_d = (idx_q >= ppcLast) ? '0 : idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// ADC receive path: registers both ADC channels, converts them to signed samples,
// drops the first SETTLE_CYCLES strobes after enable and frames the rest.
module adc_capture
  import adc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int IN_W          = ADC_W,
  parameter int OUT_W         = SAMPLE_W
) (
  input  logic             CLK_65,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] ptos_x_ciclo,
  input  logic             sync_valid,
  input  logic             clear_otr,
  input  logic [IN_W-1:0]  ADC_DA,
  input  logic [IN_W-1:0]  ADC_DB,
  input  logic             ADC_OTR_A,
  input  logic             ADC_OTR_B,
  output logic             ADC_CLK_A,
  output logic             ADC_CLK_B,
  output logic             ADC_OEB_A,
  output logic             ADC_OEB_B,
  output logic [OUT_W-1:0] data_a_out,
  output logic [OUT_W-1:0] data_b_out,
  output logic             data_valid_out,
  output logic             sop,
  output logic             eop,
  output logic             otr_sticky,
  output logic             busy
);

  localparam bit               SKIP_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [IN_W-1:0]  daS1_q;
  logic [IN_W-1:0]  dbS1_q;
  logic             otrS1_q;
  logic             validS1_q;

  adc_state_e       state_q;
  adc_state_e       state_d;
  logic [CNT_W-1:0] settleCnt_q;
  logic [CNT_W-1:0] settleCnt_d;
  logic [CNT_W-1:0] ppc_q;
  logic [CNT_W-1:0] ppc_d;

  logic [OUT_W-1:0] dataA_q;
  logic [OUT_W-1:0] dataB_q;
  logic             valid_q;
  logic             sop_q;
  logic             eop_q;
  logic             sticky_q;

  logic             emit;
  logic             frameClear;
  logic             frameSop;
  logic             frameEop;

  assign ADC_CLK_A = CLK_65;
  assign ADC_CLK_B = CLK_65;
  assign ADC_OEB_A = 1'b0;
  assign ADC_OEB_B = 1'b0;

  // A sample whose emit edge coincides with enable low is discarded.
  assign emit       = (state_q == RUN) && validS1_q && enable;
  assign frameClear = (state_q != RUN) || !enable;

  always_ff @(posedge CLK_65 or posedge reset) begin
    if (reset) begin
      daS1_q    <= '0;
      dbS1_q    <= '0;
      otrS1_q   <= 1'b0;
      validS1_q <= 1'b0;
    end else begin
      daS1_q    <= ADC_DA;
      dbS1_q    <= ADC_DB;
      otrS1_q   <= ADC_OTR_A | ADC_OTR_B;
      validS1_q <= sync_valid;
    end
  end

  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    ppc_d       = ppc_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (SKIP_SETTLE) state_d = RUN;
          else             state_d = SETTLE;
          settleCnt_d = '0;
          ppc_d       = (ptos_x_ciclo == '0) ? CNT_W'(1) : ptos_x_ciclo;
        end
        SETTLE: begin
          if (validS1_q) begin
            if (settleCnt_q == SETTLE_LAST) state_d = RUN;
            settleCnt_d = settleCnt_q + CNT_W'(1);
          end
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_65 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      ppc_q       <= '0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      ppc_q       <= ppc_d;
    end
  end

  adc_frame_counter uFrame (
    .clk_i    (CLK_65),
    .rst_i    (reset),
    .ppc_i    (ppc_q),
    .advance_i(emit),
    .clear_i  (frameClear),
    .sop_o    (frameSop),
    .eop_o    (frameEop)
  );

  // Data holds between strobes; a new out-of-range flag outranks a clear request.
  always_ff @(posedge CLK_65 or posedge reset) begin
    if (reset) begin
      dataA_q  <= '0;
      dataB_q  <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q <= emit;
      sop_q   <= emit & frameSop;
      eop_q   <= emit & frameEop;
      if (emit) begin
        dataA_q <= offset_to_signed(daS1_q);
        dataB_q <= offset_to_signed(dbS1_q);
      end
      if (emit && otrS1_q) begin
        sticky_q <= 1'b1;
      end else if (clear_otr) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign data_a_out     = dataA_q;
  assign data_b_out     = dataB_q;
  assign data_valid_out = valid_q;
  assign sop            = sop_q;
  assign eop            = eop_q;
  assign otr_sticky     = sticky_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: a strobe-level reference model predicts every
// emitted sample and a negedge monitor compares what the DUT presents.
module tb_adc_capture;

  localparam int SETTLE = 16;

  logic        CLK_65 = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] ptos_x_ciclo;
  logic        sync_valid;
  logic        clear_otr;
  logic [13:0] ADC_DA;
  logic [13:0] ADC_DB;
  logic        ADC_OTR_A;
  logic        ADC_OTR_B;
  logic        ADC_CLK_A;
  logic        ADC_CLK_B;
  logic        ADC_OEB_A;
  logic        ADC_OEB_B;
  logic [15:0] data_a_out;
  logic [15:0] data_b_out;
  logic        data_valid_out;
  logic        sop;
  logic        eop;
  logic        otr_sticky;
  logic        busy;

  adc_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .CLK_65        (CLK_65),
    .reset         (reset),
    .enable        (enable),
    .ptos_x_ciclo  (ptos_x_ciclo),
    .sync_valid    (sync_valid),
    .clear_otr     (clear_otr),
    .ADC_DA        (ADC_DA),
    .ADC_DB        (ADC_DB),
    .ADC_OTR_A     (ADC_OTR_A),
    .ADC_OTR_B     (ADC_OTR_B),
    .ADC_CLK_A     (ADC_CLK_A),
    .ADC_CLK_B     (ADC_CLK_B),
    .ADC_OEB_A     (ADC_OEB_A),
    .ADC_OEB_B     (ADC_OEB_B),
    .data_a_out    (data_a_out),
    .data_b_out    (data_b_out),
    .data_valid_out(data_valid_out),
    .sop           (sop),
    .eop           (eop),
    .otr_sticky    (otr_sticky),
    .busy          (busy)
  );

  always #5 CLK_65 = ~CLK_65;

  int checks   = 0;
  int failures = 0;
  int cycleCnt = 0;

  always @(posedge CLK_65) cycleCnt <= cycleCnt + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sop;
    logic        eop;
    logic        otr;
    int          cyc;
  } exp_t;

  exp_t expQ[$];

  // Reference model: strobe counting since the enable rise, frame index, sticky flag.
  bit          mPrevEn;
  bit          mPendValid;
  bit          mPendEn;
  bit          mPendOtr;
  logic [13:0] mPendA;
  logic [13:0] mPendB;
  int          mPendCyc;
  int          mCnt;
  int          mIdx;
  int          mPpc;
  bit          mSticky;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cycleCnt);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    mPrevEn    = 1'b0;
    mPendValid = 1'b0;
    mPendEn    = 1'b0;
    mPendOtr   = 1'b0;
    mPendA     = '0;
    mPendB     = '0;
    mPendCyc   = 0;
    mCnt       = 0;
    mIdx       = 0;
    mPpc       = 1;
    mSticky    = 1'b0;
  endtask

  // A strobe driven in cycle k appears two edges later, provided enable stays high
  // through cycle k+1 and the settle quota since the enable rise is already used up.
  task automatic modelCycle(input bit en, input bit sv, input logic [13:0] da, input logic [13:0] db,
                            input bit otr, input bit clr, input logic [15:0] ppc);
    exp_t e;
    bit   emitted;
    emitted = 1'b0;
    if (mPendValid && mPendEn && en) begin
      if (mCnt < SETTLE) begin
        mCnt++;
      end else begin
        emitted = 1'b1;
        e.a   = 16'(int'(mPendA) - 8192);
        e.b   = 16'(int'(mPendB) - 8192);
        e.sop = (mIdx == 0);
        e.eop = (mIdx == mPpc - 1);
        e.cyc = mPendCyc + 2;
        mIdx  = (mIdx + 1) % mPpc;
      end
    end
    if (emitted && mPendOtr) mSticky = 1'b1;
    else if (clr)            mSticky = 1'b0;
    if (emitted) begin
      e.otr = mSticky;
      expQ.push_back(e);
    end
    if (en && !mPrevEn) begin
      mCnt = 0;
      mIdx = 0;
      mPpc = (ppc == 16'd0) ? 1 : int'(ppc);
    end
    if (!en) mIdx = 0;
    mPrevEn    = en;
    mPendValid = sv;
    mPendEn    = en;
    mPendA     = da;
    mPendB     = db;
    mPendOtr   = otr;
    mPendCyc   = cycleCnt;
  endtask

  task automatic applyStimulus(input bit en, input bit sv, input logic [13:0] da, input logic [13:0] db,
                               input bit oa, input bit ob, input bit clr, input logic [15:0] ppc);
    @(posedge CLK_65);
    #1;
    enable       = en;
    sync_valid   = sv;
    ADC_DA       = da;
    ADC_DB       = db;
    ADC_OTR_A    = oa;
    ADC_OTR_B    = ob;
    clear_otr    = clr;
    ptos_x_ciclo = ppc;
    modelCycle(en, sv, da, db, oa | ob, clr, ppc);
  endtask

  task automatic applyRandom(input int n, input bit en, input bit toggle, input logic [15:0] ppc,
                             input int otrPct);
    bit phase;
    phase = 1'b1;
    for (int i = 0; i < n; i++) begin
      applyStimulus(en, toggle ? phase : 1'b1, 14'($urandom), 14'($urandom),
                    ($urandom_range(0, 99) < otrPct), ($urandom_range(0, 99) < otrPct), 1'b0, ppc);
      phase = ~phase;
    end
  endtask

  task automatic applyIdle(input int n, input bit en, input logic [15:0] ppc);
    for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 14'($urandom), 14'($urandom), 1'b0, 1'b0, 1'b0, ppc);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_data_a"}, data_a_out, 32'd0);
    checkOutput({tag, "_data_b"}, data_b_out, 32'd0);
    checkOutput({tag, "_valid"}, data_valid_out, 32'd0);
    checkOutput({tag, "_sop"}, sop, 32'd0);
    checkOutput({tag, "_eop"}, eop, 32'd0);
    checkOutput({tag, "_otr"}, otr_sticky, 32'd0);
    checkOutput({tag, "_busy"}, busy, 32'd0);
    checkOutput({tag, "_oeb_a"}, ADC_OEB_A, 32'd0);
    checkOutput({tag, "_oeb_b"}, ADC_OEB_B, 32'd0);
    checkOutput({tag, "_adc_clk_a"}, ADC_CLK_A, CLK_65);
    checkOutput({tag, "_adc_clk_b"}, ADC_CLK_B, CLK_65);
  endtask

  // Monitor: pops one expectation per strobe; between strobes the data must hold.
  logic [15:0] lastA = '0;
  logic [15:0] lastB = '0;
  exp_t        monE;

  always @(negedge CLK_65) begin
    if (reset) begin
      lastA = '0;
      lastB = '0;
    end else if (data_valid_out) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", data_valid_out, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("data_a", data_a_out, monE.a);
        checkOutput("data_b", data_b_out, monE.b);
        checkOutput("sop", sop, monE.sop);
        checkOutput("eop", eop, monE.eop);
        checkOutput("otr_sticky", otr_sticky, monE.otr);
        checkOutput("emit_cycle", cycleCnt, monE.cyc);
        lastA = monE.a;
        lastB = monE.b;
      end
    end else begin
      checkOutput("hold_a", data_a_out, lastA);
      checkOutput("hold_b", data_b_out, lastB);
    end
  end

  initial begin
    int        latency;
    bit        found;
    logic [13:0] codes [4];
    codes[0] = 14'h0000;
    codes[1] = 14'h3FFF;
    codes[2] = 14'h2001;
    codes[3] = 14'h1FFF;

    reset        = 1'b1;
    enable       = 1'b0;
    sync_valid   = 1'b0;
    clear_otr    = 1'b0;
    ADC_DA       = 14'h2000;
    ADC_DB       = 14'h2000;
    ADC_OTR_A    = 1'b0;
    ADC_OTR_B    = 1'b0;
    ptos_x_ciclo = 16'd8;
    modelReset();

    repeat (3) @(posedge CLK_65);
    #1;
    checkResetOutputs("reset");
    reset = 1'b0;
    applyIdle(2, 1'b0, 16'd8);

    // Latency from enable to the first emitted strobe with settle quota 16.
    applyStimulus(1'b1, 1'b1, 14'h2000, 14'($urandom), 1'b0, 1'b0, 1'b0, 16'd8);
    latency = 0;
    found   = 1'b0;
    for (int n = 1; n <= 40 && !found; n++) begin
      applyStimulus(1'b1, 1'b1, 14'h2000, 14'($urandom), 1'b0, 1'b0, 1'b0, 16'd8);
      if (data_valid_out) begin
        found   = 1'b1;
        latency = n;
      end
    end
    checkOutput("first_valid_latency", latency, 32'd18);
    checkOutput("busy_run", busy, 32'd1);
    applyRandom(30, 1'b1, 1'b0, 16'd8, 0);

    // Conversion boundary codes on both channels.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, codes[i], codes[3 - i], 1'b0, 1'b0, 1'b0, 16'd8);
    applyRandom(20, 1'b1, 1'b0, 16'd8, 0);

    // One sample per frame, then a zero frame length treated the same way.
    applyIdle(3, 1'b0, 16'd1);
    checkOutput("busy_idle", busy, 32'd0);
    applyRandom(40, 1'b1, 1'b0, 16'd1, 0);
    applyIdle(3, 1'b0, 16'd0);
    applyRandom(40, 1'b1, 1'b0, 16'd0, 0);

    // Drop enable with idx 3 pending, re-enable with 4 and change the length while busy.
    applyIdle(3, 1'b0, 16'd8);
    for (int i = 0; i < 60 && !(mCnt >= SETTLE && mIdx == 3); i++) applyRandom(1, 1'b1, 1'b0, 16'd8, 0);
    applyIdle(2, 1'b0, 16'd8);
    applyRandom(1, 1'b1, 1'b0, 16'd4, 0);
    applyRandom(40, 1'b1, 1'b0, 16'd7, 0);

    // Out-of-range handling: ignored in settle, sticky in run, set beats clear.
    applyIdle(2, 1'b0, 16'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 14'($urandom), 14'($urandom), 1'b0, 1'b1, 1'b0, 16'd4);
    applyRandom(20, 1'b1, 1'b0, 16'd4, 0);
    checkOutput("otr_settle_ignored", otr_sticky, mSticky);
    applyStimulus(1'b1, 1'b1, 14'($urandom), 14'($urandom), 1'b0, 1'b1, 1'b0, 16'd4);
    applyIdle(3, 1'b1, 16'd4);
    checkOutput("otr_run_set", otr_sticky, mSticky);
    applyStimulus(1'b1, 1'b0, 14'($urandom), 14'($urandom), 1'b0, 1'b0, 1'b1, 16'd4);
    applyIdle(3, 1'b1, 16'd4);
    checkOutput("otr_clear_alone", otr_sticky, mSticky);
    applyStimulus(1'b1, 1'b1, 14'($urandom), 14'($urandom), 1'b1, 1'b0, 1'b0, 16'd4);
    applyStimulus(1'b1, 1'b0, 14'($urandom), 14'($urandom), 1'b0, 1'b0, 1'b1, 16'd4);
    applyIdle(3, 1'b1, 16'd4);
    checkOutput("otr_set_beats_clear", otr_sticky, mSticky);
    applyStimulus(1'b1, 1'b0, 14'($urandom), 14'($urandom), 1'b0, 1'b0, 1'b1, 16'd4);
    applyIdle(3, 1'b1, 16'd4);
    checkOutput("otr_clear_again", otr_sticky, mSticky);

    // Alternating strobes with five-sample frames, then an asynchronous reset mid-cycle.
    applyIdle(2, 1'b0, 16'd5);
    applyRandom(60, 1'b1, 1'b1, 16'd5, 3);
    applyStimulus(1'b1, 1'b1, 14'($urandom), 14'($urandom), 1'b1, 1'b0, 1'b0, 16'd5);
    applyIdle(2, 1'b1, 16'd5);
    checkOutput("busy_before_reset", busy, 32'd1);
    checkOutput("otr_before_reset", otr_sticky, mSticky);
    @(posedge CLK_65);
    #3;
    reset      = 1'b1;
    enable     = 1'b0;
    sync_valid = 1'b0;
    modelReset();
    #1;
    checkResetOutputs("async_reset");
    @(posedge CLK_65);
    #1;
    reset = 1'b0;
    applyIdle(4, 1'b0, 16'd5);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
